// File: rtl/pulse_meas.sv
// pulse_meas: measures high/low segment widths of a synchronized level, queued as {sat, level, width}.
// Latency: an edge pulse p at cycle t makes its entry visible on m_valid/m_width/m_level/m_sat at t+1.
// Backpressure: the m_valid/m_ready FIFO holds DEPTH entries; a push into a full FIFO without a same-cycle pop is lost and sets sticky drop.
// Optional glitch filter: define PULSE_MEAS_GLITCH_FILTER_EN to suppress segments shorter than MIN_W cycles.
`timescale 1ns/1ps
module pulse_meas #(
   parameter int CNT_W = 16,
   parameter int DEPTH = 4,
   parameter int MIN_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p,
   input  logic             q,
   input  logic             clr,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] m_width,
   output logic             m_level,
   output logic             m_sat,
   output logic             drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_W);
`ifdef PULSE_MEAS_GLITCH_FILTER_EN
   localparam bit FILT_EN = 1'b1;
`else
   localparam bit FILT_EN = 1'b0;
`endif

   typedef enum logic {IDLE, MEAS} state_t;

   typedef struct packed {
      logic             sat;
      logic             level;
      logic [CNT_W-1:0] width;
   } entry_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_req;
   entry_t           new_entry;

   entry_t           mem [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             full, empty;
   logic             do_push, do_pop;
   entry_t           head;

   // Next-state and counter: first edge only arms the counter since the
   // segment start before it is unknown; later edges close a segment.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      push_req = 1'b0;
      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (p) begin
                  state_d = MEAS;
                  cnt_d   = CNT_ONE;
               end
            end
            MEAS: begin
               if (p) begin
                  cnt_d    = CNT_ONE;
                  push_req = !FILT_EN || (cnt_q >= MIN_CNT);
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // FSM state and width counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // During the edge cycle q still shows the level of the segment just ending.
   assign new_entry.sat   = (cnt_q == CNT_MAX);
   assign new_entry.level = q;
   assign new_entry.width = cnt_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign do_pop  = !empty && m_ready && !clr;
   assign do_push = push_req && (!full || do_pop);

   // Entry storage; a push into a full FIFO with a concurrent pop reuses the head slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wptr_q[AW-1:0]] <= new_entry;
      end
   end

   // Read/write pointers and sticky drop flag; clr flushes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         drop   <= 1'b0;
      end else if (clr) begin
         wptr_q <= '0;
         rptr_q <= '0;
         drop   <= 1'b0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         if (push_req && full && !do_pop) drop <= 1'b1;
      end
   end

   // Head entry is read straight from storage; it only changes on a pop or flush.
   assign head    = mem[rptr_q[AW-1:0]];
   assign m_valid = !empty;
   assign m_width = head.width;
   assign m_level = head.level;
   assign m_sat   = head.sat;

endmodule
